// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared constants and helpers for updown_mod_counter and its
//   next-value sub-module.
//   - MODE_WRAP / MODE_SAT : encodings of the `sat` input
//   - DIR_DOWN / DIR_UP    : encodings of the `up_ndown` input
//   - action_e             : the single action taken on a clock edge
//   - decode_action()      : resolves sclr > en_load > ce > hold
package counter_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   localparam logic DIR_DOWN  = 1'b0;
   localparam logic DIR_UP    = 1'b1;

   typedef enum logic [1:0] {
      ACT_HOLD  = 2'd0,
      ACT_CLEAR = 2'd1,
      ACT_LOAD  = 2'd2,
      ACT_COUNT = 2'd3
   } action_e;

   // Exactly one action per edge; earlier controls mask later ones.
   function automatic action_e decode_action(input logic sclr,
                                             input logic en_load,
                                             input logic ce);
      if (sclr)         return ACT_CLEAR;
      else if (en_load) return ACT_LOAD;
      else if (ce)      return ACT_COUNT;
      else              return ACT_HOLD;
   endfunction

endpackage

// File: rtl/mod_step_next.sv
// mod_step_next
//   Combinational next-count and wrap-flag logic for one counting step
//   of a modulo-MODULUS counter, in wrap or saturate mode.
//   Parameters: WIDTH (count width), MODULUS (2..2**WIDTH).
//   Ports:
//     cnt      in  WIDTH  current count (always < MODULUS)
//     step     in  WIDTH  step magnitude (< MODULUS; 0 holds)
//     up_ndown in  1      DIR_UP / DIR_DOWN
//     sat      in  1      MODE_WRAP / MODE_SAT
//     nxt      out WIDTH  count after the step
//     wrap     out 1      step crossed a range boundary (wrapped or clipped)
module mod_step_next
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 2 ** WIDTH
) (
   input  logic [WIDTH-1:0] cnt,
   input  logic [WIDTH-1:0] step,
   input  logic             up_ndown,
   input  logic             sat,
   output logic [WIDTH-1:0] nxt,
   output logic             wrap
);

   // One extra bit so that MODULUS itself (up to 2**WIDTH) and cnt+step
   // are representable without overflow.
   localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

   logic [WIDTH:0] cnt_w;
   logic [WIDTH:0] step_w;
   logic [WIDTH:0] sum;

   assign cnt_w  = {1'b0, cnt};
   assign step_w = {1'b0, step};
   assign sum    = cnt_w + step_w;

   // NOTE: every output gets a default before the branches so no path
   // leaves it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      nxt  = cnt;
      wrap = 1'b0;
      if (up_ndown == DIR_UP) begin
         if (sum < MOD_W) begin
            nxt = sum[WIDTH-1:0];
         end else begin
            wrap = 1'b1;
            nxt  = (sat == MODE_SAT) ? MAX_V : WIDTH'(sum - MOD_W);
         end
      end else begin
         if (cnt >= step) begin
            nxt = cnt - step;
         end else begin
            wrap = 1'b1;
            // cnt < step here, so cnt+MODULUS-step lands inside 0..MODULUS-1.
            nxt  = (sat == MODE_SAT) ? '0 : WIDTH'(cnt_w + MOD_W - step_w);
         end
      end
   end

endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter
//   Parametrised up/down modulo counter with synchronous clear, synchronous
//   load (clamped to MODULUS-1), programmable step and wrap/saturate modes.
//   Optional feature macro: UPDOWN_MOD_COUNTER_STICKY_EN adds a sticky
//   wrap flag with its own clear input.
//   Parameters: WIDTH (>=2), MODULUS (2..2**WIDTH).
//   Ports:
//     clk         in  1      rising-edge clock
//     reset       in  1      asynchronous active-low reset
//     sclr        in  1      synchronous clear (highest synchronous priority)
//     en_load     in  1      synchronous load of `load`
//     load        in  WIDTH  load value, clamped to MODULUS-1
//     ce          in  1      count enable
//     up_ndown    in  1      1 up, 0 down
//     step        in  WIDTH  step magnitude, 1..MODULUS-1 (0 holds)
//     sat         in  1      0 wrap, 1 saturate
//     cnt         out WIDTH  registered count
//     wrap        out 1      registered pulse on wrap or saturation clip
//     at_max      out 1      cnt == MODULUS-1
//     at_min      out 1      cnt == 0
//     wrap_clr    in  1      (sticky build) clears wrap_sticky
//     wrap_sticky out 1      (sticky build) latched record of any wrap
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 2 ** WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sclr,
   input  logic             en_load,
   input  logic [WIDTH-1:0] load,
   input  logic             ce,
   input  logic             up_ndown,
   input  logic [WIDTH-1:0] step,
   input  logic             sat,
   output logic [WIDTH-1:0] cnt,
   output logic             wrap,
   output logic             at_max,
   output logic             at_min
`ifdef UPDOWN_MOD_COUNTER_STICKY_EN
  ,input  logic             wrap_clr,
   output logic             wrap_sticky
`endif
);

   localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

   action_e          action;
   logic [WIDTH-1:0] step_cnt;
   logic             step_wrap;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] cnt_next;
   logic             wrap_next;

   mod_step_next #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_step (
      .cnt      (cnt),
      .step     (step),
      .up_ndown (up_ndown),
      .sat      (sat),
      .nxt      (step_cnt),
      .wrap     (step_wrap)
   );

   assign action       = decode_action(sclr, en_load, ce);
   assign load_clamped = ({1'b0, load} < MOD_W) ? load : MAX_V;

   always_comb begin
      cnt_next  = cnt;
      wrap_next = 1'b0;
      case (action)
         ACT_CLEAR: cnt_next = '0;
         ACT_LOAD:  cnt_next = load_clamped;
         ACT_COUNT: begin
            cnt_next  = step_cnt;
            wrap_next = step_wrap;
         end
         default:   cnt_next = cnt;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         wrap <= 1'b0;
      end else begin
         cnt  <= cnt_next;
         wrap <= wrap_next;
      end
   end

   assign at_max = (cnt == MAX_V);
   assign at_min = (cnt == '0);

`ifdef UPDOWN_MOD_COUNTER_STICKY_EN
   // Set takes precedence so a wrap coinciding with wrap_clr is not lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrap_sticky <= 1'b0;
      end else if (wrap_next) begin
         wrap_sticky <= 1'b1;
      end else if (wrap_clr || sclr) begin
         wrap_sticky <= 1'b0;
      end
   end
`endif

   // Simulation-only guard: a step of MODULUS or more is outside the
   // supported range and would produce counts outside 0..MODULUS-1.
   step_legal: assert property (@(posedge clk) disable iff (!reset)
      (action == ACT_COUNT) |-> ({1'b0, step} < MOD_W));

endmodule
